// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the 5-stage 20-bit pipeline control.
//   - instruction field layout and opcode constants
//   - hazard FSM state encoding and forward-select encoding
//   - decode predicates writes_rd / uses_rs1 / uses_rs2
package pipe_pkg;

    localparam int INSTR_W = 20;

    // Field bit positions: opcode [19:16], rd [15:12], rs1 [11:8], rs2 [7:4]
    localparam int OPC_LO = 16;
    localparam int RD_LO  = 12;
    localparam int RS1_LO = 8;
    localparam int RS2_LO = 4;

    typedef logic [3:0] opcode_t;
    typedef logic [3:0] reg_t;

    typedef struct packed {
        opcode_t op;
        reg_t    rd;
        reg_t    rs1;
        reg_t    rs2;
        logic [3:0] imm;
    } instr_t;

    localparam opcode_t OP_NOP   = 4'd0;
    localparam opcode_t OP_ADD   = 4'd1;
    localparam opcode_t OP_SUB   = 4'd2;
    localparam opcode_t OP_AND   = 4'd3;
    localparam opcode_t OP_OR    = 4'd4;
    localparam opcode_t OP_LOAD  = 4'd5;
    localparam opcode_t OP_STORE = 4'd6;
    localparam opcode_t OP_BEQ   = 4'd7;
    localparam opcode_t OP_JMP   = 4'd8;

    localparam logic [1:0] ST_RUN        = 2'd0;
    localparam logic [1:0] ST_LOAD_STALL = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT   = 2'd2;
    localparam logic [1:0] ST_BR_FLUSH   = 2'd3;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // Bubble counter only has to hold LOAD_STALL_CYCLES-1 (max 14)
    localparam int BUB_W = 4;

    function automatic logic writes_rd(opcode_t op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_LOAD);
    endfunction

    function automatic logic uses_rs1(opcode_t op);
        return (op != OP_NOP) && (op != OP_JMP);
    endfunction

    function automatic logic uses_rs2(opcode_t op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_STORE) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: combinational ALU-operand forwarding select.
//   instr_ex/instr_mem/instr_wb : words held in ID/EX, EX/MEM, MEM/WB
//   fwd_a_sel / fwd_b_sel       : 00 RF, 01 EX/MEM alu result, 10 MEM/WB value
import pipe_pkg::*;

module fwd_unit (
    input  logic [INSTR_W-1:0] instr_ex,
    input  logic [INSTR_W-1:0] instr_mem,
    input  logic [INSTR_W-1:0] instr_wb,
    output logic [1:0]         fwd_a_sel,
    output logic [1:0]         fwd_b_sel
);

    instr_t ex, mem, wb;
    assign ex  = instr_t'(instr_ex);
    assign mem = instr_t'(instr_mem);
    assign wb  = instr_t'(instr_wb);

    // A LOAD in EX/MEM has no data yet, so it can only forward from MEM/WB.
    function automatic logic [1:0] pick(reg_t rs, instr_t m, instr_t w);
        if (writes_rd(m.op) && m.op != OP_LOAD && m.rd != 4'd0 && m.rd == rs)
            return FWD_EXMEM;
        else if (writes_rd(w.op) && w.rd != 4'd0 && w.rd == rs)
            return FWD_MEMWB;
        else
            return FWD_RF;
    endfunction

    assign fwd_a_sel = pick(ex.rs1, mem, wb);
    assign fwd_b_sel = pick(ex.rs2, mem, wb);

    logic unused_fields;
    assign unused_fields = ^{ex.op, ex.rd, ex.imm, mem.rs1, mem.rs2, mem.imm,
                             wb.rs1, wb.rs2, wb.imm};

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: hazard sequencer for the 5-stage pipeline.
//   inputs : clock, reset (sync, active-high), instr_id/ex/mem/wb,
//            branch_taken (EX resolved taken), mem_busy (MEM must hold)
//   outputs: pc_en, ifid_en/flush, idex_en/flush, exmem_en, memwb_en/flush,
//            fwd_a_sel/fwd_b_sel, stall_cycles (saturating), state_o (debug)
// Controls are decoded from this cycle's decision so they act in the same
// cycle as the trigger; the state register only carries multi-cycle holds
// (remaining load bubbles, memory wait plus the state it interrupted).
import pipe_pkg::*;

module pipeline_hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [INSTR_W-1:0]  instr_id,
    input  logic [INSTR_W-1:0]  instr_ex,
    input  logic [INSTR_W-1:0]  instr_mem,
    input  logic [INSTR_W-1:0]  instr_wb,
    input  logic                branch_taken,
    input  logic                mem_busy,
    output logic                pc_en,
    output logic                ifid_en,
    output logic                ifid_flush,
    output logic                idex_en,
    output logic                idex_flush,
    output logic                exmem_en,
    output logic                memwb_en,
    output logic                memwb_flush,
    output logic [1:0]          fwd_a_sel,
    output logic [1:0]          fwd_b_sel,
    output logic [CNT_W-1:0]    stall_cycles,
    output logic [1:0]          state_o
);

    localparam logic [BUB_W-1:0] BUB_INIT = BUB_W'(LOAD_STALL_CYCLES - 1);

    logic [1:0]       state_q, state_d, resume_q, resume_d, eff_state, act;
    logic [BUB_W-1:0] bub_q, bub_d;
    logic [1:0]       fwd_a, fwd_b;
    logic             load_use;

    instr_t id, ex;
    assign id = instr_t'(instr_id);
    assign ex = instr_t'(instr_ex);

    assign load_use = (ex.op == OP_LOAD) && (ex.rd != 4'd0) &&
                      ((uses_rs1(id.op) && id.rs1 == ex.rd) ||
                       (uses_rs2(id.op) && id.rs2 == ex.rd));

    // During a memory wait, decide as if the interrupted state were current.
    assign eff_state = (state_q == ST_MEM_WAIT) ? resume_q : state_q;

    always_comb begin
        act      = ST_RUN;
        state_d  = ST_RUN;
        resume_d = ST_RUN;
        bub_d    = bub_q;
        if (mem_busy) begin
            // Branch in EX is frozen too; it is re-presented on release.
            act      = ST_MEM_WAIT;
            state_d  = ST_MEM_WAIT;
            resume_d = eff_state;
        end else if (branch_taken) begin
            act   = ST_BR_FLUSH;
            bub_d = '0;
        end else if (eff_state == ST_LOAD_STALL) begin
            // bub_q is nonzero whenever LOAD_STALL is held
            act     = ST_LOAD_STALL;
            bub_d   = bub_q - 1'b1;
            state_d = (bub_d != '0) ? ST_LOAD_STALL : ST_RUN;
        end else if (load_use) begin
            act     = ST_LOAD_STALL;
            bub_d   = BUB_INIT;
            state_d = (BUB_INIT != '0) ? ST_LOAD_STALL : ST_RUN;
        end
    end

    fwd_unit u_fwd (
        .instr_ex  (instr_ex),
        .instr_mem (instr_mem),
        .instr_wb  (instr_wb),
        .fwd_a_sel (fwd_a),
        .fwd_b_sel (fwd_b)
    );

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        memwb_flush = 1'b0;
        fwd_a_sel   = fwd_a;
        fwd_b_sel   = fwd_b;
        if (reset) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            memwb_flush = 1'b1;
            fwd_a_sel   = FWD_RF;
            fwd_b_sel   = FWD_RF;
        end else begin
            case (act)
                ST_LOAD_STALL: begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end
                ST_MEM_WAIT: begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_en  = 1'b0;
                    exmem_en = 1'b0;
                    memwb_en = 1'b0;
                end
                ST_BR_FLUSH: begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_RUN;
            resume_q     <= ST_RUN;
            bub_q        <= '0;
            stall_cycles <= '0;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
            bub_q    <= bub_d;
            if (!pc_en && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;
        end
    end

    assign state_o = state_q;

    logic unused_fields;
    assign unused_fields = ^{id.rd, id.imm, ex.rs1, ex.rs2, ex.imm};

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;
    import pipe_pkg::*;

    logic clock = 1'b0;
    logic reset;
    logic [19:0] instr_id, instr_ex, instr_mem, instr_wb;
    logic branch_taken, mem_busy;

    logic pc_en1, ifid_en1, ifid_flush1, idex_en1, idex_flush1, exmem_en1, memwb_en1, memwb_flush1;
    logic [1:0] fa1, fb1, st1;
    logic [15:0] sc1;
    logic pc_en3, ifid_en3, ifid_flush3, idex_en3, idex_flush3, exmem_en3, memwb_en3, memwb_flush3;
    logic [1:0] fa3, fb3, st3;
    logic [15:0] sc3;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) u1 (
        .clock(clock), .reset(reset), .instr_id(instr_id), .instr_ex(instr_ex),
        .instr_mem(instr_mem), .instr_wb(instr_wb), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .pc_en(pc_en1), .ifid_en(ifid_en1), .ifid_flush(ifid_flush1),
        .idex_en(idex_en1), .idex_flush(idex_flush1), .exmem_en(exmem_en1),
        .memwb_en(memwb_en1), .memwb_flush(memwb_flush1), .fwd_a_sel(fa1),
        .fwd_b_sel(fb1), .stall_cycles(sc1), .state_o(st1));

    pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) u3 (
        .clock(clock), .reset(reset), .instr_id(instr_id), .instr_ex(instr_ex),
        .instr_mem(instr_mem), .instr_wb(instr_wb), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .pc_en(pc_en3), .ifid_en(ifid_en3), .ifid_flush(ifid_flush3),
        .idex_en(idex_en3), .idex_flush(idex_flush3), .exmem_en(exmem_en3),
        .memwb_en(memwb_en3), .memwb_flush(memwb_flush3), .fwd_a_sel(fa3),
        .fwd_b_sel(fb3), .stall_cycles(sc3), .state_o(st3));

    function automatic logic [19:0] mk(logic [3:0] op, logic [3:0] rd, logic [3:0] rs1, logic [3:0] rs2);
        return {op, rd, rs1, rs2, 4'h0};
    endfunction

    // advance one clock; inputs change 1ns after the edge, checks at negedge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    task automatic nops();
        instr_id = '0; instr_ex = '0; instr_mem = '0; instr_wb = '0;
        branch_taken = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        nops();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        // inputs that would forward and stall if reset did not override
        tick();
        reset = 1'b1;
        instr_ex = mk(OP_ADD, 4'd1, 4'd2, 4'd2);
        instr_mem = mk(OP_ADD, 4'd2, 4'd0, 4'd0);
        instr_wb = mk(OP_SUB, 4'd2, 4'd0, 4'd0);
        settle();
        total++;
        if ({pc_en1, ifid_en1, idex_en1, exmem_en1, memwb_en1} !== 5'b00000) begin
            bad++; $display("FAIL reset_en got=%b exp=00000", {pc_en1, ifid_en1, idex_en1, exmem_en1, memwb_en1});
        end
        total++;
        if ({ifid_flush1, idex_flush1, memwb_flush1} !== 3'b111) begin
            bad++; $display("FAIL reset_flush got=%b exp=111", {ifid_flush1, idex_flush1, memwb_flush1});
        end
        total++;
        if ({fa1, fb1} !== 4'b0000) begin
            bad++; $display("FAIL reset_fwd got=%b exp=0000", {fa1, fb1});
        end
        tick();
        reset = 1'b0;
        nops();
        settle();
        total++;
        if ({st1, sc1, pc_en1, idex_flush1} !== {2'd0, 16'd0, 1'b1, 1'b0}) begin
            bad++; $display("FAIL post_reset got st=%0d sc=%0d pc_en=%b flush=%b exp st=0 sc=0 pc_en=1 flush=0",
                            st1, sc1, pc_en1, idex_flush1);
        end
    endtask

    task automatic test_load_use_1();
        do_reset();
        instr_ex = mk(OP_LOAD, 4'd3, 4'd0, 4'd0);
        instr_id = mk(OP_ADD, 4'd4, 4'd3, 4'd1);
        settle();
        total++;
        if ({pc_en1, ifid_en1, idex_flush1, exmem_en1, memwb_en1} !== 5'b00111) begin
            bad++; $display("FAIL lu1_bubble got=%b exp=00111", {pc_en1, ifid_en1, idex_flush1, exmem_en1, memwb_en1});
        end
        tick();
        instr_ex = '0;
        instr_mem = mk(OP_LOAD, 4'd3, 4'd0, 4'd0);
        settle();
        total++;
        if ({pc_en1, ifid_en1, idex_flush1, st1} !== {3'b110, 2'd0}) begin
            bad++; $display("FAIL lu1_resume got=%b st=%0d exp=110 st=0", {pc_en1, ifid_en1, idex_flush1}, st1);
        end
        tick();
        instr_id = '0;
        instr_ex = mk(OP_ADD, 4'd4, 4'd3, 4'd1);
        instr_mem = '0;
        instr_wb = mk(OP_LOAD, 4'd3, 4'd0, 4'd0);
        settle();
        total++;
        if ({fa1, fb1, sc1} !== {2'b10, 2'b00, 16'd1}) begin
            bad++; $display("FAIL lu1_fwd got fa=%b fb=%b sc=%0d exp fa=10 fb=00 sc=1", fa1, fb1, sc1);
        end
    endtask

    task automatic test_stall_mem_busy();
        // expected pc_en per cycle: bubble, wait, wait, bubble, bubble, run
        logic [5:0] exp_pc;
        logic [5:0] exp_bsy;
        exp_pc  = 6'b100000;
        exp_bsy = 6'b000110;
        do_reset();
        instr_ex = mk(OP_LOAD, 4'd3, 4'd0, 4'd0);
        instr_id = mk(OP_ADD, 4'd4, 4'd3, 4'd1);
        for (int c = 0; c < 6; c++) begin
            mem_busy = exp_bsy[c];
            settle();
            total++;
            if (pc_en3 !== exp_pc[c]) begin
                bad++; $display("FAIL ls3_pc_en cyc=%0d got=%b exp=%b", c, pc_en3, exp_pc[c]);
            end
            if (c == 2) begin
                total++;
                if ({idex_en3, exmem_en3, memwb_en3, idex_flush3, st3} !== {4'b0000, 2'd2}) begin
                    bad++; $display("FAIL ls3_wait got=%b st=%0d exp=0000 st=2",
                                    {idex_en3, exmem_en3, memwb_en3, idex_flush3}, st3);
                end
            end
            if (c == 3) begin
                total++;
                if ({ifid_en3, idex_flush3, exmem_en3} !== 3'b011) begin
                    bad++; $display("FAIL ls3_rebubble got=%b exp=011", {ifid_en3, idex_flush3, exmem_en3});
                end
            end
            tick();
            instr_ex = '0;
            instr_mem = mk(OP_LOAD, 4'd3, 4'd0, 4'd0);
        end
        settle();
        total++;
        if ({sc3, st3} !== {16'd5, 2'd0}) begin
            bad++; $display("FAIL ls3_count got sc=%0d st=%0d exp sc=5 st=0", sc3, st3);
        end
    endtask

    task automatic test_forward();
        do_reset();
        instr_ex = mk(OP_SUB, 4'd1, 4'd2, 4'd2);
        instr_mem = mk(OP_ADD, 4'd2, 4'd5, 4'd6);
        instr_wb = mk(OP_SUB, 4'd2, 4'd7, 4'd8);
        settle();
        total++;
        if ({fa1, fb1} !== 4'b0101) begin
            bad++; $display("FAIL fwd_both_mem got=%b exp=0101", {fa1, fb1});
        end
        tick();
        instr_mem = mk(OP_STORE, 4'd2, 4'd5, 4'd6);
        settle();
        total++;
        if ({fa1, fb1} !== 4'b1010) begin
            bad++; $display("FAIL fwd_store_mem got=%b exp=1010", {fa1, fb1});
        end
        tick();
        instr_mem = mk(OP_LOAD, 4'd2, 4'd5, 4'd0);
        instr_wb = mk(OP_OR, 4'd9, 4'd0, 4'd0);
        settle();
        total++;
        if ({fa1, fb1} !== 4'b0000) begin
            bad++; $display("FAIL fwd_load_mem got=%b exp=0000", {fa1, fb1});
        end
        tick();
        instr_ex = mk(OP_AND, 4'd1, 4'd7, 4'd9);
        instr_mem = mk(OP_ADD, 4'd7, 4'd0, 4'd0);
        instr_wb = mk(OP_LOAD, 4'd9, 4'd0, 4'd0);
        settle();
        total++;
        if ({fa1, fb1} !== 4'b0110) begin
            bad++; $display("FAIL fwd_split got=%b exp=0110", {fa1, fb1});
        end
    endtask

    task automatic test_branch();
        do_reset();
        instr_ex = mk(OP_LOAD, 4'd3, 4'd0, 4'd0);
        instr_id = mk(OP_ADD, 4'd4, 4'd3, 4'd1);
        branch_taken = 1'b1;
        settle();
        total++;
        if ({pc_en1, ifid_en1, ifid_flush1, idex_flush1, pc_en3} !== 5'b11111) begin
            bad++; $display("FAIL br_vs_lu got=%b exp=11111", {pc_en1, ifid_en1, ifid_flush1, idex_flush1, pc_en3});
        end
        tick();
        nops();
        settle();
        total++;
        if ({pc_en1, ifid_flush1, idex_flush1, pc_en3, sc1, sc3} !== {4'b1001, 32'd0}) begin
            bad++; $display("FAIL br_after got=%b sc1=%0d sc3=%0d exp=1001 sc=0",
                            {pc_en1, ifid_flush1, idex_flush1, pc_en3}, sc1, sc3);
        end
        // branch aborts a running 3-cycle stall
        tick();
        instr_ex = mk(OP_LOAD, 4'd3, 4'd0, 4'd0);
        instr_id = mk(OP_ADD, 4'd4, 4'd3, 4'd1);
        tick();
        nops();
        branch_taken = 1'b1;
        settle();
        total++;
        if ({pc_en3, ifid_flush3, idex_flush3} !== 3'b111) begin
            bad++; $display("FAIL br_abort got=%b exp=111", {pc_en3, ifid_flush3, idex_flush3});
        end
        tick();
        branch_taken = 1'b0;
        settle();
        total++;
        if ({pc_en3, st3, sc3} !== {1'b1, 2'd0, 16'd1}) begin
            bad++; $display("FAIL br_abort_after pc_en=%b st=%0d sc=%0d exp pc_en=1 st=0 sc=1", pc_en3, st3, sc3);
        end
        // branch while memory busy is ignored
        tick();
        mem_busy = 1'b1;
        branch_taken = 1'b1;
        settle();
        total++;
        if ({pc_en1, ifid_flush1, idex_flush1, idex_en1} !== 4'b0000) begin
            bad++; $display("FAIL br_busy got=%b exp=0000", {pc_en1, ifid_flush1, idex_flush1, idex_en1});
        end
    endtask

    task automatic test_r0();
        do_reset();
        instr_ex = mk(OP_LOAD, 4'd0, 4'd1, 4'd0);
        instr_id = mk(OP_ADD, 4'd5, 4'd0, 4'd0);
        settle();
        total++;
        if ({pc_en1, pc_en3, idex_flush1} !== 3'b110) begin
            bad++; $display("FAIL r0_nostall got=%b exp=110", {pc_en1, pc_en3, idex_flush1});
        end
        tick();
        instr_id = '0;
        instr_ex = mk(OP_ADD, 4'd5, 4'd0, 4'd0);
        instr_mem = mk(OP_ADD, 4'd0, 4'd1, 4'd1);
        instr_wb = mk(OP_LOAD, 4'd0, 4'd1, 4'd0);
        settle();
        total++;
        if ({fa1, fb1} !== 4'b0000) begin
            bad++; $display("FAIL r0_fwd got=%b exp=0000", {fa1, fb1});
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        instr_ex = mk(OP_LOAD, 4'd3, 4'd0, 4'd0);
        instr_id = mk(OP_ADD, 4'd4, 4'd3, 4'd1);
        tick();
        instr_ex = '0;
        tick();
        reset = 1'b1;
        settle();
        total++;
        if ({pc_en3, ifid_en3, idex_en3, exmem_en3, memwb_en3, ifid_flush3, idex_flush3, memwb_flush3} !== 8'b00000111) begin
            bad++; $display("FAIL rst_stall got=%b exp=00000111",
                            {pc_en3, ifid_en3, idex_en3, exmem_en3, memwb_en3, ifid_flush3, idex_flush3, memwb_flush3});
        end
        tick();
        reset = 1'b0;
        nops();
        settle();
        total++;
        if ({pc_en3, idex_flush3, st3, sc3} !== {2'b10, 2'd0, 16'd0}) begin
            bad++; $display("FAIL rst_stall_after pc_en=%b flush=%b st=%0d sc=%0d exp 1 0 0 0", pc_en3, idex_flush3, st3, sc3);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        mem_busy = 1'b1;
        for (int i = 0; i < 65539; i++) @(posedge clock);
        #1;
        mem_busy = 1'b0;
        settle();
        total++;
        if ({sc1, sc3} !== {16'hFFFF, 16'hFFFF}) begin
            bad++; $display("FAIL sat got sc1=%h sc3=%h exp=ffff", sc1, sc3);
        end
    endtask

    initial begin
        reset = 1'b1;
        nops();
        test_reset();
        test_load_use_1();
        test_stall_mem_busy();
        test_forward();
        test_branch();
        test_r0();
        test_reset_mid_stall();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
